// File: rtl/pc_branch_unit.sv
// Program counter and conditional-branch stage: holds the PC, assembles a two-byte
// jump target from the data bus and commits it when the selected ALU flag condition holds.
module pc_branch_unit #(
  parameter int          PC_WIDTH     = 16,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic                i_clk,
  input  logic                i_nReset,
  input  logic [7:0]          i_bus,
  output logic [7:0]          o_bus,
  output logic                o_busNOE,
  input  logic                i_flagNegative,
  input  logic                i_flagZero,
  input  logic                i_flagOverflow,
  input  logic                i_flagCarry,
  input  logic                i_ctrlPcNOE,
  input  logic                i_ctrlPcHiSel,
  input  logic                i_ctrlPcInc,
  input  logic                i_ctrlJmpLoNWE,
  input  logic                i_ctrlJmpHiNWE,
  input  logic                i_ctrlJmpNEn,
  input  logic [2:0]          i_ctrlJmpCond,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_jumpTaken,
  output logic                o_jumpFault
);

  // State encoding is {loValid, hiValid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HI    = 2'b01,
    LO    = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic                taken_q, taken_d;
  logic                fault_q, fault_d;
  logic                cond_true;
  logic                commit;

  assign commit = ~i_ctrlJmpNEn;

  always_comb begin
    cond_true = 1'b0;
    case (i_ctrlJmpCond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = i_flagZero;
      3'b010:  cond_true = ~i_flagZero;
      3'b011:  cond_true = i_flagCarry;
      3'b100:  cond_true = ~i_flagCarry;
      3'b101:  cond_true = i_flagNegative;
      3'b110:  cond_true = i_flagNegative ^ i_flagOverflow;
      default: cond_true = i_flagOverflow;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pc_d     = pc_q;
    taken_d  = 1'b0;
    fault_d  = 1'b0;

    if (i_ctrlPcInc) begin
      pc_d = pc_q + 1'b1;
    end

    // A commit consumes the pre-edge target; any same-cycle byte write is dropped
    if (commit) begin
      state_d = EMPTY;
      if (state_q == FULL) begin
        if (cond_true) begin
          pc_d    = target_q;
          taken_d = 1'b1;
        end
      end else begin
        fault_d = 1'b1;
      end
    end else begin
      if (!i_ctrlJmpLoNWE) begin
        target_d[7:0] = i_bus;
      end
      if (!i_ctrlJmpHiNWE) begin
        target_d[15:8] = i_bus;
      end
      state_d = state_t'({state_q[1] | ~i_ctrlJmpLoNWE,
                          state_q[0] | ~i_ctrlJmpHiNWE});
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nReset) begin
      state_q  <= EMPTY;
      pc_q     <= RESET_VECTOR;
      target_q <= '0;
      taken_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      taken_q  <= taken_d;
      fault_q  <= fault_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_jumpTaken = taken_q;
  assign o_jumpFault = fault_q;
  assign o_bus       = i_ctrlPcHiSel ? pc_q[15:8] : pc_q[7:0];
  assign o_busNOE    = i_ctrlPcNOE;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: increment/wrap, target loading, all condition
// codes, fault pulses, same-cycle commit/write and reset during a load.
module tb_pc_branch_unit;

  logic        i_clk = 1'b0;
  logic        i_nReset;
  logic [7:0]  i_bus;
  logic [7:0]  o_bus;
  logic        o_busNOE;
  logic        i_flagNegative, i_flagZero, i_flagOverflow, i_flagCarry;
  logic        i_ctrlPcNOE, i_ctrlPcHiSel, i_ctrlPcInc;
  logic        i_ctrlJmpLoNWE, i_ctrlJmpHiNWE, i_ctrlJmpNEn;
  logic [2:0]  i_ctrlJmpCond;
  logic [15:0] o_pc;
  logic        o_jumpTaken, o_jumpFault;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pc_branch_unit #(.PC_WIDTH(16), .RESET_VECTOR(16'h0100)) dut (
    .i_clk          (i_clk),
    .i_nReset       (i_nReset),
    .i_bus          (i_bus),
    .o_bus          (o_bus),
    .o_busNOE       (o_busNOE),
    .i_flagNegative (i_flagNegative),
    .i_flagZero     (i_flagZero),
    .i_flagOverflow (i_flagOverflow),
    .i_flagCarry    (i_flagCarry),
    .i_ctrlPcNOE    (i_ctrlPcNOE),
    .i_ctrlPcHiSel  (i_ctrlPcHiSel),
    .i_ctrlPcInc    (i_ctrlPcInc),
    .i_ctrlJmpLoNWE (i_ctrlJmpLoNWE),
    .i_ctrlJmpHiNWE (i_ctrlJmpHiNWE),
    .i_ctrlJmpNEn   (i_ctrlJmpNEn),
    .i_ctrlJmpCond  (i_ctrlJmpCond),
    .o_pc           (o_pc),
    .o_jumpTaken    (o_jumpTaken),
    .o_jumpFault    (o_jumpFault)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_ctrlPcInc    = 1'b0;
    i_ctrlJmpLoNWE = 1'b1;
    i_ctrlJmpHiNWE = 1'b1;
    i_ctrlJmpNEn   = 1'b1;
    i_ctrlJmpCond  = 3'b000;
  endtask

  task automatic load_target(input logic [7:0] hi, input logic [7:0] lo, input bit lo_first);
    idle();
    i_bus = lo_first ? lo : hi;
    if (lo_first) i_ctrlJmpLoNWE = 1'b0; else i_ctrlJmpHiNWE = 1'b0;
    tick();
    idle();
    i_bus = lo_first ? hi : lo;
    if (lo_first) i_ctrlJmpHiNWE = 1'b0; else i_ctrlJmpLoNWE = 1'b0;
    tick();
    idle();
  endtask

  task automatic commit(input logic [2:0] cond, input logic inc);
    idle();
    i_ctrlJmpCond = cond;
    i_ctrlJmpNEn  = 1'b0;
    i_ctrlPcInc   = inc;
    tick();
    idle();
  endtask

  task automatic test_reset();
    i_nReset = 1'b0;
    i_ctrlPcInc = 1'b1;
    tick();
    tick();
    i_nReset = 1'b1;
    idle();
    total_cnt++;
    if (o_pc !== 16'h0100) $display("FAIL reset_pc: got %h want 0100", o_pc); else pass_cnt++;
    total_cnt++;
    if (o_jumpTaken !== 1'b0 || o_jumpFault !== 1'b0)
      $display("FAIL reset_pulses: taken=%b fault=%b want 0/0", o_jumpTaken, o_jumpFault);
    else pass_cnt++;
    $display("reset: pc=%h taken=%b fault=%b", o_pc, o_jumpTaken, o_jumpFault);
  endtask

  task automatic test_increment();
    i_ctrlPcInc = 1'b1;
    repeat (3) tick();
    idle();
    total_cnt++;
    if (o_pc !== 16'h0103) $display("FAIL inc3_pc: got %h want 0103", o_pc); else pass_cnt++;
    i_ctrlPcHiSel = 1'b0;
    #1;
    total_cnt++;
    if (o_bus !== 8'h03) $display("FAIL bus_lo: got %h want 03", o_bus); else pass_cnt++;
    i_ctrlPcHiSel = 1'b1;
    #1;
    total_cnt++;
    if (o_bus !== 8'h01) $display("FAIL bus_hi: got %h want 01", o_bus); else pass_cnt++;
    i_ctrlPcNOE = 1'b0;
    #1;
    total_cnt++;
    if (o_busNOE !== 1'b0) $display("FAIL bus_noe0: got %b want 0", o_busNOE); else pass_cnt++;
    i_ctrlPcNOE = 1'b1;
    #1;
    total_cnt++;
    if (o_busNOE !== 1'b1) $display("FAIL bus_noe1: got %b want 1", o_busNOE); else pass_cnt++;
    $display("increment: pc=%h", o_pc);
  endtask

  task automatic test_wrap();
    load_target(8'hFF, 8'hFF, 1'b0);
    commit(3'b000, 1'b0);
    total_cnt++;
    if (o_pc !== 16'hFFFF || o_jumpTaken !== 1'b1)
      $display("FAIL wrap_setup: pc=%h taken=%b want FFFF/1", o_pc, o_jumpTaken);
    else pass_cnt++;
    i_ctrlPcInc = 1'b1;
    tick();
    idle();
    total_cnt++;
    if (o_pc !== 16'h0000 || o_jumpTaken !== 1'b0)
      $display("FAIL wrap: pc=%h taken=%b want 0000/0", o_pc, o_jumpTaken);
    else pass_cnt++;
    $display("wrap: pc=%h", o_pc);
  endtask

  task automatic test_jump_fault();
    load_target(8'h12, 8'h34, 1'b0);
    commit(3'b000, 1'b0);
    total_cnt++;
    if (o_pc !== 16'h1234 || o_jumpTaken !== 1'b1 || o_jumpFault !== 1'b0)
      $display("FAIL jump_1234: pc=%h taken=%b fault=%b want 1234/1/0", o_pc, o_jumpTaken, o_jumpFault);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (o_jumpTaken !== 1'b0) $display("FAIL taken_one_cycle: got %b want 0", o_jumpTaken); else pass_cnt++;
    commit(3'b000, 1'b0);
    total_cnt++;
    if (o_pc !== 16'h1234 || o_jumpTaken !== 1'b0 || o_jumpFault !== 1'b1)
      $display("FAIL fault_empty: pc=%h taken=%b fault=%b want 1234/0/1", o_pc, o_jumpTaken, o_jumpFault);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (o_jumpFault !== 1'b0) $display("FAIL fault_one_cycle: got %b want 0", o_jumpFault); else pass_cnt++;
    $display("jump_fault: pc=%h", o_pc);
  endtask

  task automatic test_cond_zero();
    load_target(8'hBE, 8'hEF, 1'b1);
    i_flagZero = 1'b0;
    commit(3'b001, 1'b1);
    total_cnt++;
    if (o_pc !== 16'h1235 || o_jumpTaken !== 1'b0 || o_jumpFault !== 1'b0)
      $display("FAIL z_not_taken: pc=%h taken=%b fault=%b want 1235/0/0", o_pc, o_jumpTaken, o_jumpFault);
    else pass_cnt++;
    load_target(8'hBE, 8'hEF, 1'b0);
    i_flagZero = 1'b1;
    commit(3'b001, 1'b1);
    total_cnt++;
    if (o_pc !== 16'hBEEF || o_jumpTaken !== 1'b1)
      $display("FAIL z_taken_inc_ignored: pc=%h taken=%b want BEEF/1", o_pc, o_jumpTaken);
    else pass_cnt++;
    i_flagZero = 1'b0;
    $display("cond_zero: pc=%h", o_pc);
  endtask

  task automatic test_cond_table();
    logic [3:0]  flag_set [2];
    logic [7:0]  exp_taken [2];
    logic [15:0] exp_pc;
    logic [15:0] tgt;
    // flags are {N,Z,V,C}; expected bit c = condition c true
    flag_set[0]  = 4'b1001;
    exp_taken[0] = 8'b01101101;
    flag_set[1]  = 4'b0110;
    exp_taken[1] = 8'b11010011;
    exp_pc = 16'hBEEF;
    for (int s = 0; s < 2; s++) begin
      {i_flagNegative, i_flagZero, i_flagOverflow, i_flagCarry} = flag_set[s];
      for (int c = 0; c < 8; c++) begin
        tgt = (s == 0 ? 16'hA000 : 16'hB000) + 16'(c);
        load_target(tgt[15:8], tgt[7:0], c[0]);
        commit(c[2:0], 1'b0);
        if (exp_taken[s][c]) exp_pc = tgt;
        total_cnt++;
        if (o_pc !== exp_pc || o_jumpTaken !== exp_taken[s][c] || o_jumpFault !== 1'b0)
          $display("FAIL cond_%0d_set%0d: pc=%h taken=%b fault=%b want %h/%b/0",
                   c, s, o_pc, o_jumpTaken, o_jumpFault, exp_pc, exp_taken[s][c]);
        else pass_cnt++;
        $display("cond %0d set %0d: pc=%h taken=%b", c, s, o_pc, o_jumpTaken);
      end
    end
    {i_flagNegative, i_flagZero, i_flagOverflow, i_flagCarry} = 4'b0000;
  endtask

  task automatic test_cond_signed();
    load_target(8'h56, 8'h78, 1'b0);
    i_flagNegative = 1'b1;
    i_flagOverflow = 1'b0;
    commit(3'b110, 1'b0);
    total_cnt++;
    if (o_pc !== 16'h5678 || o_jumpTaken !== 1'b1)
      $display("FAIL lt_taken: pc=%h taken=%b want 5678/1", o_pc, o_jumpTaken);
    else pass_cnt++;
    load_target(8'h9A, 8'hBC, 1'b0);
    i_flagOverflow = 1'b1;
    commit(3'b110, 1'b0);
    total_cnt++;
    if (o_pc !== 16'h5678 || o_jumpTaken !== 1'b0)
      $display("FAIL lt_not_taken: pc=%h taken=%b want 5678/0", o_pc, o_jumpTaken);
    else pass_cnt++;
    i_flagNegative = 1'b0;
    i_flagOverflow = 1'b0;
    $display("cond_signed: pc=%h", o_pc);
  endtask

  task automatic test_commit_with_write();
    load_target(8'h20, 8'h00, 1'b0);
    i_bus = 8'h55;
    i_ctrlJmpLoNWE = 1'b0;
    i_ctrlJmpNEn = 1'b0;
    tick();
    idle();
    total_cnt++;
    if (o_pc !== 16'h2000 || o_jumpTaken !== 1'b1)
      $display("FAIL commit_write_old_target: pc=%h taken=%b want 2000/1", o_pc, o_jumpTaken);
    else pass_cnt++;
    // Only a high byte now: the dropped low byte must not count as valid
    i_bus = 8'h30;
    i_ctrlJmpHiNWE = 1'b0;
    tick();
    commit(3'b000, 1'b0);
    total_cnt++;
    if (o_pc !== 16'h2000 || o_jumpFault !== 1'b1 || o_jumpTaken !== 1'b0)
      $display("FAIL write_discarded: pc=%h fault=%b taken=%b want 2000/1/0", o_pc, o_jumpFault, o_jumpTaken);
    else pass_cnt++;
    $display("commit_with_write: pc=%h", o_pc);
  endtask

  task automatic test_overwrite();
    i_bus = 8'h11; i_ctrlJmpLoNWE = 1'b0; tick();
    i_bus = 8'h22; tick();
    idle();
    i_bus = 8'h33; i_ctrlJmpHiNWE = 1'b0; tick();
    commit(3'b000, 1'b0);
    total_cnt++;
    if (o_pc !== 16'h3322 || o_jumpTaken !== 1'b1)
      $display("FAIL overwrite: pc=%h taken=%b want 3322/1", o_pc, o_jumpTaken);
    else pass_cnt++;
    $display("overwrite: pc=%h", o_pc);
  endtask

  task automatic test_reset_mid_load();
    idle();
    i_bus = 8'h77; i_ctrlJmpLoNWE = 1'b0; tick();
    idle();
    i_bus = 8'h66; i_ctrlJmpHiNWE = 1'b0; i_ctrlPcInc = 1'b1;
    i_nReset = 1'b0;
    tick();
    i_nReset = 1'b1;
    idle();
    total_cnt++;
    if (o_pc !== 16'h0100) $display("FAIL reset_mid_load_pc: got %h want 0100", o_pc); else pass_cnt++;
    commit(3'b000, 1'b0);
    total_cnt++;
    if (o_pc !== 16'h0100 || o_jumpFault !== 1'b1 || o_jumpTaken !== 1'b0)
      $display("FAIL reset_then_commit: pc=%h fault=%b taken=%b want 0100/1/0", o_pc, o_jumpFault, o_jumpTaken);
    else pass_cnt++;
    $display("reset_mid_load: pc=%h fault=%b", o_pc, o_jumpFault);
  endtask

  initial begin
    i_nReset = 1'b0;
    i_bus = 8'h00;
    {i_flagNegative, i_flagZero, i_flagOverflow, i_flagCarry} = 4'b0000;
    i_ctrlPcNOE = 1'b1;
    i_ctrlPcHiSel = 1'b0;
    idle();
    test_reset();
    test_increment();
    test_wrap();
    test_jump_fault();
    test_cond_zero();
    test_cond_table();
    test_cond_signed();
    test_commit_with_write();
    test_overwrite();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
